// File: rtl/vga_fb_scanout.sv
// VGA scan-out stage: 640x480@60 raster timing plus a low-resolution 3-bit-colour
// framebuffer. Each framebuffer cell is shown as a block of (1<<SCALE_SHIFT) x
// (1<<SCALE_SHIFT) pixels. The framebuffer is written from the CPU side and read
// here in raster order.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous active-low reset
//   fb_wen       framebuffer write strobe
//   fb_waddr     cell index (row*COLS + col); indices >= CELLS are dropped
//   fb_wdata     cell colour {r,g,b}
//   rgb          registered pixel colour, 0 outside the active area
//   hs, vs       registered syncs
//   vblank       high while the line counter is outside the active lines
//   frame_start  one-cycle pulse for pixel (0,0)
//   frame_cnt    count of frame_start pulses, wraps at 16 bits
//
// Every output trails the raster counters by two clock edges
// (stage 1: address/flags, stage 2: RAM read and output register).
module vga_fb_scanout #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned SCALE_SHIFT = 3,
  parameter bit          HS_ACTIVE   = 1'b0,
  parameter bit          VS_ACTIVE   = 1'b1,
  parameter int unsigned ADDR_W      = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fb_wen,
  input  logic [ADDR_W-1:0] fb_waddr,
  input  logic [2:0]        fb_wdata,
  output logic [2:0]        rgb,
  output logic              hs,
  output logic              vs,
  output logic              vblank,
  output logic              frame_start,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned COLS    = H_ACTIVE >> SCALE_SHIFT;
  localparam int unsigned ROWS    = V_ACTIVE >> SCALE_SHIFT;
  localparam int unsigned CELLS   = COLS * ROWS;
  localparam int unsigned CX_W    = $clog2(H_TOTAL);
  localparam int unsigned CY_W    = $clog2(V_TOTAL);
  localparam int unsigned MEM_AW  = $clog2(CELLS);

  localparam logic [CX_W-1:0]   CX_LAST  = CX_W'(H_TOTAL - 1);
  localparam logic [CX_W-1:0]   CX_ACT   = CX_W'(H_ACTIVE);
  localparam logic [CX_W-1:0]   HS_START = CX_W'(H_ACTIVE + H_FP);
  localparam logic [CX_W-1:0]   HS_END   = CX_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CY_W-1:0]   CY_LAST  = CY_W'(V_TOTAL - 1);
  localparam logic [CY_W-1:0]   CY_ACT   = CY_W'(V_ACTIVE);
  localparam logic [CY_W-1:0]   VS_START = CY_W'(V_ACTIVE + V_FP);
  localparam logic [CY_W-1:0]   VS_END   = CY_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CY_W-1:0]   ROW_MASK = CY_W'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] CELLS_A  = ADDR_W'(CELLS);

  // Raster counters and the address of the first cell of the current cell row.
  logic [CX_W-1:0]   cx;
  logic [CY_W-1:0]   cy;
  logic [CY_W-1:0]   cy_next;
  logic [ADDR_W-1:0] line_base;

  assign cy_next = cy + CY_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cx        <= '0;
      cy        <= '0;
      line_base <= '0;
    end else if (cx == CX_LAST) begin
      cx <= '0;
      if (cy == CY_LAST) begin
        cy        <= '0;
        line_base <= '0;
      end else begin
        cy <= cy_next;
        // Step to the next cell row when the new line starts a fresh block of lines.
        if (((cy_next & ROW_MASK) == '0) && (cy_next < CY_ACT)) begin
          line_base <= line_base + COLS_A;
        end
      end
    end else begin
      cx <= cx + CX_W'(1);
    end
  end

  // Stage 1: cell address and per-pixel flags.
  logic [ADDR_W-1:0] addr_s1;
  logic              active_s1;
  logic              hs_s1;
  logic              vs_s1;
  logic              vblank_s1;
  logic              fs_s1;

  always_comb begin
    addr_s1   = line_base + ADDR_W'(cx >> SCALE_SHIFT);
    active_s1 = (cx < CX_ACT) && (cy < CY_ACT);
    hs_s1     = ((cx >= HS_START) && (cx < HS_END)) ? HS_ACTIVE : ~HS_ACTIVE;
    vs_s1     = ((cy >= VS_START) && (cy < VS_END)) ? VS_ACTIVE : ~VS_ACTIVE;
    vblank_s1 = (cy >= CY_ACT);
    fs_s1     = (cx == '0) && (cy == '0);
  end

  logic [ADDR_W-1:0] addr_q;
  logic              active_q;
  logic              hs_q;
  logic              vs_q;
  logic              vblank_q;
  logic              fs_q;

  // Sync flags reset to their inactive level so no stray pulse leaks out after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      active_q <= 1'b0;
      hs_q     <= ~HS_ACTIVE;
      vs_q     <= ~VS_ACTIVE;
      vblank_q <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      addr_q   <= addr_s1;
      active_q <= active_s1;
      hs_q     <= hs_s1;
      vs_q     <= vs_s1;
      vblank_q <= vblank_s1;
      fs_q     <= fs_s1;
    end
  end

  // Framebuffer: not reset. Writes while reset is low, or beyond the last cell, are dropped.
  logic [2:0] mem [CELLS];

  always_ff @(posedge clk) begin
    if (fb_wen && reset && (fb_waddr < CELLS_A)) begin
      mem[fb_waddr[MEM_AW-1:0]] <= fb_wdata;
    end
  end

  // Stage 2: the RAM read samples the old contents when a write hits the same cell.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb         <= '0;
      hs          <= ~HS_ACTIVE;
      vs          <= ~VS_ACTIVE;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      rgb         <= active_q ? mem[addr_q[MEM_AW-1:0]] : 3'b000;
      hs          <= hs_q;
      vs          <= vs_q;
      vblank      <= vblank_q;
      frame_start <= fs_q;
      if (frame_start) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout with reduced timing (80x55 total, 64x48 active,
// 8x6 cells) so several frames fit in a short run. Edge n counts posedges since
// reset release; the output after edge n shows raster pixel p = n - 2.
module tb_vga_fb_scanout;

  localparam int HA = 64, HF = 4, HSY = 8, HB = 4;
  localparam int VA = 48, VF = 2, VSY = 2, VB = 3;
  localparam int HT = HA + HF + HSY + HB;  // 80
  localparam int VT = VA + VF + VSY + VB;  // 55
  localparam int FRAME = HT * VT;          // 4400
  localparam int CELLS = (HA / 8) * (VA / 8);

  logic        clk = 1'b0;
  logic        reset;
  logic        fb_wen;
  logic [12:0] fb_waddr;
  logic [2:0]  fb_wdata;
  logic [2:0]  rgb;
  logic        hs, vs, vblank, frame_start;
  logic [15:0] frame_cnt;

  vga_fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .SCALE_SHIFT(3), .HS_ACTIVE(1'b0), .VS_ACTIVE(1'b1), .ADDR_W(13)
  ) dut (
    .clk(clk), .reset(reset), .fb_wen(fb_wen), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata),
    .rgb(rgb), .hs(hs), .vs(vs), .vblank(vblank), .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          frame;
    int          x;
    int          y;
    logic [2:0]  rgb;
    logic        hs;
    logic        vs;
    logic        vb;
    logic        fs;
    logic [15:0] fc;
  } vec_t;

  vec_t vecs[$];
  int   edge_n;
  int   n_checks;
  int   n_errors;

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // {rgb, hs, vs, vblank, frame_start, frame_cnt}
  function automatic logic [31:0] pack(input logic [2:0] c, input logic h, input logic v,
                                       input logic b, input logic f, input logic [15:0] n);
    return {9'd0, c, h, v, b, f, n};
  endfunction

  task automatic run_to(input int target);
    if (edge_n > target) check("schedule", edge_n, target);
    while (edge_n < target) step();
  endtask

  task automatic fb_write(input int a, input int d);
    fb_wen   = 1'b1;
    fb_waddr = 13'(a);
    fb_wdata = 3'(d);
    step();
    fb_wen   = 1'b0;
  endtask

  task automatic add(input int f, input int x, input int y, input int c, input bit h,
                     input bit v, input bit b, input bit s, input int n);
    vec_t t;
    t.frame = f; t.x = x; t.y = y; t.rgb = 3'(c);
    t.hs = h; t.vs = v; t.vb = b; t.fs = s; t.fc = 16'(n);
    vecs.push_back(t);
  endtask

  int hs_low, vs_high, hs_falls, vs_rises, bad_gap, last_fall, vs_rise_edge;
  logic hs_prev, vs_prev;

  initial begin
    edge_n = 0; n_checks = 0; n_errors = 0;
    reset = 1'b0; fb_wen = 1'b0; fb_waddr = '0; fb_wdata = '0;

    // Expected pixels: cell = (y>>3)*8 + (x>>3); fb[0]=4, fb[9]=3, fb[47]=7, rest 0.
    //   f  x   y   rgb hs vs vb fs fc
    add(0,  0,  0,  4, 1, 0, 0, 1, 0);
    add(0,  1,  0,  4, 1, 0, 0, 0, 1);
    add(0,  7,  7,  4, 1, 0, 0, 0, 1);
    add(0,  8,  7,  0, 1, 0, 0, 0, 1);
    add(0, 16,  7,  0, 1, 0, 0, 0, 1);
    add(0, 63,  7,  0, 1, 0, 0, 0, 1);
    add(0, 64,  7,  0, 1, 0, 0, 0, 1);
    add(0, 67,  7,  0, 1, 0, 0, 0, 1);
    add(0, 68,  7,  0, 0, 0, 0, 0, 1);
    add(0, 75,  7,  0, 0, 0, 0, 0, 1);
    add(0, 76,  7,  0, 1, 0, 0, 0, 1);
    add(0,  7,  8,  0, 1, 0, 0, 0, 1);
    add(0,  8,  8,  3, 1, 0, 0, 0, 1);
    add(0, 15, 15,  3, 1, 0, 0, 0, 1);
    add(0, 16, 15,  0, 1, 0, 0, 0, 1);
    add(0, 55, 40,  0, 1, 0, 0, 0, 1);
    add(0, 56, 40,  7, 1, 0, 0, 0, 1);
    add(0, 63, 47,  7, 1, 0, 0, 0, 1);
    add(0, 64, 47,  0, 1, 0, 0, 0, 1);
    add(0,  0, 48,  0, 1, 0, 1, 0, 1);
    add(0, 79, 49,  0, 1, 0, 1, 0, 1);
    add(0,  0, 50,  0, 1, 1, 1, 0, 1);
    add(0, 70, 51,  0, 0, 1, 1, 0, 1);
    add(0, 79, 51,  0, 1, 1, 1, 0, 1);
    add(0,  0, 52,  0, 1, 0, 1, 0, 1);
    add(0, 79, 54,  0, 1, 0, 1, 0, 1);
    add(1,  0,  0,  4, 1, 0, 0, 1, 1);
    add(1,  1,  0,  4, 1, 0, 0, 0, 2);

    // Reset state, with a write attempt that must be dropped.
    fb_wen = 1'b1; fb_waddr = 13'd2; fb_wdata = 3'd6;
    step(); step();
    fb_wen = 1'b0;
    check("reset_state", pack(rgb, hs, vs, vblank, frame_start, frame_cnt),
          pack(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0));

    // Load the framebuffer, then restart timing (contents survive reset).
    reset = 1'b1;
    for (int i = 0; i < CELLS; i++) fb_write(i, 0);
    fb_write(0, 4);
    fb_write(9, 3);
    fb_write(47, 7);
    fb_write(48, 7);
    fb_write(8191, 7);
    reset = 1'b0;
    fb_wen = 1'b1; fb_waddr = 13'd2; fb_wdata = 3'd6;
    step(); step();
    fb_wen = 1'b0;
    reset = 1'b1;
    edge_n = 0;

    foreach (vecs[i]) begin
      run_to(vecs[i].frame * FRAME + vecs[i].y * HT + vecs[i].x + 2);
      check($sformatf("vec%0d_x%0d_y%0d", i, vecs[i].x, vecs[i].y),
            pack(rgb, hs, vs, vblank, frame_start, frame_cnt),
            pack(vecs[i].rgb, vecs[i].hs, vecs[i].vs, vecs[i].vb, vecs[i].fs, vecs[i].fc));
    end

    // One full output period of sync statistics.
    hs_low = 0; vs_high = 0; hs_falls = 0; vs_rises = 0; bad_gap = 0;
    last_fall = -1; vs_rise_edge = -1;
    hs_prev = hs; vs_prev = vs;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (!hs) hs_low++;
      if (vs) vs_high++;
      if (hs_prev && !hs) begin
        hs_falls++;
        if (last_fall >= 0 && (edge_n - last_fall) != HT) bad_gap++;
        last_fall = edge_n;
      end
      if (!vs_prev && vs) begin
        vs_rises++;
        vs_rise_edge = edge_n;
      end
      hs_prev = hs; vs_prev = vs;
    end
    check("hs_low_cycles", hs_low, VT * HSY);
    check("vs_high_cycles", vs_high, VSY * HT);
    check("hs_falls", hs_falls, VT);
    check("hs_period_errs", bad_gap, 0);
    check("vs_rises", vs_rises, 1);
    check("vs_rise_edge", vs_rise_edge, FRAME + (VA + VF) * HT + 2);

    // Write cell 5 on the edge its read is issued for pixel (40,0) of frame 2.
    run_to(2 * FRAME + 40 + 1);
    fb_wen = 1'b1; fb_waddr = 13'd5; fb_wdata = 3'd5;
    step();
    fb_wen = 1'b0;
    check("rw_same_edge_old", rgb, 0);
    step();
    check("rw_next_pixel_new", rgb, 5);
    run_to(2 * FRAME + HT + 40 + 2);
    check("rw_next_line_new", rgb, 5);

    // Mid-frame reset at (70,50): sync and blanking are all asserted there.
    run_to(2 * FRAME + 50 * HT + 70 + 2);
    check("pre_reset", pack(rgb, hs, vs, vblank, frame_start, frame_cnt),
          pack(3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3));
    reset = 1'b0;
    fb_wen = 1'b1; fb_waddr = 13'd0; fb_wdata = 3'd1;
    #1;
    check("reset_immediate", pack(rgb, hs, vs, vblank, frame_start, frame_cnt),
          pack(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", pack(rgb, hs, vs, vblank, frame_start, frame_cnt),
          pack(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
    fb_wen = 1'b0;
    reset = 1'b1;
    edge_n = 0;
    step();
    check("rel_edge1_fs", frame_start, 0);
    step();
    check("rel_edge2", pack(rgb, hs, vs, vblank, frame_start, frame_cnt),
          pack(3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0));
    step();
    check("rel_edge3_fc", frame_cnt, 1);

    // Preload the counter just below wrap while no pulse is pending.
    force dut.frame_cnt = 16'hFFFF;
    step();
    release dut.frame_cnt;
    check("fc_preload", frame_cnt, 16'hFFFF);
    run_to(FRAME + 2);
    check("wrap_pulse", {frame_start, frame_cnt}, {1'b1, 16'hFFFF});
    step();
    check("wrap_zero", frame_cnt, 0);
    step();
    check("wrap_hold", frame_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
